maj_net_evaluator: RTL
======================

Name: maj_net_evaluator

Overview:
- Programmable, time-multiplexed evaluator for 7-input majority-inverter networks.
- One shared 3-input majority unit evaluates a stored gate list one gate per cycle, for each of the 128 input minterms in turn.
- Accumulates the 128-bit truth table of the selected output signal.
- Used in the classification flow to compute the truth table of a candidate network in hardware, instead of instantiating one combinational network per function.

Parameters:
- MAX_GATES, 16, depth of the gate program memory.
- SEL_W, 5, width of a signal selector; must satisfy 2^SEL_W >= 8+MAX_GATES.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- prog_we  in  1  gate program write strobe.
- prog_addr  in  4  gate index to write, 0..MAX_GATES-1.
- prog_data  in  3*SEL_W+3  {inv_c, inv_b, inv_a, sel_c, sel_b, sel_a}.
- num_gates  in  5  number of gates to evaluate; sampled at start.
- out_sel  in  SEL_W  signal captured into the truth table; sampled at start.
- start  in  1  begin evaluation; honoured only in IDLE.
- busy  out  1  high from the start-accept edge until done.
- done  out  1  one-cycle pulse when tt is final.
- tt  out  128  truth table; bit m = output value for minterm m.

Behaviour:
- Signal index space:
  - 0 = constant 0.
  - 1..7 = x0..x6, where xi = bit i of minterm counter m.
  - 8+k = gate k output register w[k].
- Out-of-range indices and forward references read 0. A forward reference is an index >= 8+g while gate g is being evaluated, or >= 8+G during STORE.
- Gate k computes w[k] = MAJ(a^inv_a, b^inv_b, c^inv_c), where a/b/c are the signals chosen by sel_a/sel_b/sel_c.
- Writes: prog_we writes prog_data to prog_mem[prog_addr] in IDLE or DONE only; ignored while busy. prog_addr >= MAX_GATES is ignored.
- At start, G = min(num_gates, MAX_GATES) and out_sel are latched.
- FSM: IDLE -> EVAL -> STORE -> (EVAL or DONE) -> IDLE.
  - IDLE: on start, latch G and out_sel, clear m, g, w[] and tt, set busy. Go to EVAL, or to STORE if G=0.
  - EVAL: one gate per cycle; write w[g] and increment g. After the edge that writes gate G-1, go to STORE.
  - STORE: tt[m] <= signal[out_sel]; clear g and w[]. If m==127 go to DONE, else m++ and go to EVAL (STORE if G=0).
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. tt holds its value until the next start or reset.
- Latency: the done cycle follows 128*(G+1) edges after the start-accept edge.
- start while busy or in DONE is ignored.
- Reset (any state, including mid-run): state IDLE; busy=0, done=0, tt=0, m=0, g=0, w[]=0, prog_mem all zeros.

Optional Feature:
MAJ_NET_COMPARE_EN
- Enabled: adds input tt_expected[127:0] (sampled at start) and outputs mismatch (1 bit) and first_mismatch (7 bits). Both are cleared at start.
- On each STORE whose bit differs from tt_expected[m]: set mismatch. On the first such event, also load first_mismatch=m.
- Both are valid in the done cycle and hold until the next start; both reset to 0.
- Disabled: these ports do not exist and no comparison logic is built.

Test Plan:
- G=0, out_sel=1 -> tt=128'hAAAA..AA. G=0, out_sel=0 -> tt=0. done in the 128th cycle after the start edge.
- G=1, gate0={sel 1,2,3, no inv} -> tt = 16 repeats of 8'hE8. done after 256 edges.
- G=1, gate0={0,1,2, inv_a=1} (OR) -> 128'hEEEE..EE. With inv_a=0 (AND) -> 128'h8888..88.
- Two gates, w0=AND(x0,x1), w1=MAJ(const1,w0,x2), out_sel=9 -> 16 repeats of 8'hF8. Forward reference in gate0 (sel 9) -> reads 0, so w0=AND(x0,x1) when the other operands select x0, x1.
- Mid-run rst_n low at minterm 40 -> busy=0 and tt=0 the next cycle; a restart reproduces the full result. start and prog_we pulsed while busy -> ignored, tt unchanged.
- COMPARE_EN build: tt_expected = correct value with bit 77 flipped -> mismatch=1, first_mismatch=77 at done. Correct tt_expected -> mismatch=0.

Source files
------------

// File: rtl/maj_net_evaluator.sv
// Time-multiplexed evaluator for 7-input majority-inverter networks: one shared MAJ3 unit
// walks the gate program per minterm and builds a 128-bit truth table. Optional: MAJ_NET_COMPARE_EN.
module maj_net_evaluator #(
  parameter int unsigned MAX_GATES = 16,
  parameter int unsigned SEL_W     = 5,
  localparam int unsigned ADDR_W   = $clog2(MAX_GATES),
  localparam int unsigned CNT_W    = $clog2(MAX_GATES + 1),
  localparam int unsigned PROG_W   = 3 * SEL_W + 3,
  localparam int unsigned TT_W     = 128,
  localparam int unsigned M_W      = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [PROG_W-1:0] prog_data,
  input  logic [CNT_W-1:0]  num_gates,
  input  logic [SEL_W-1:0]  out_sel,
  input  logic              start,
`ifdef MAJ_NET_COMPARE_EN
  input  logic [TT_W-1:0]   tt_expected,
  output logic              mismatch,
  output logic [M_W-1:0]    first_mismatch,
`endif
  output logic              busy,
  output logic              done,
  output logic [TT_W-1:0]   tt
);

  localparam int unsigned SIG_N = 2 ** SEL_W;

  typedef struct packed {
    logic             inv_c;
    logic             inv_b;
    logic             inv_a;
    logic [SEL_W-1:0] sel_c;
    logic [SEL_W-1:0] sel_b;
    logic [SEL_W-1:0] sel_a;
  } gate_t;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_STORE, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  gate_t                r_prog [MAX_GATES];
  logic [CNT_W-1:0]     r_gcnt;
  logic [CNT_W-1:0]     r_g;
  logic [SEL_W-1:0]     r_out_sel;
  logic [M_W-1:0]       r_m;
  logic [MAX_GATES-1:0] r_w;
  logic [TT_W-1:0]      r_tt;
  logic                 r_busy;
  logic                 r_done;

  logic [SIG_N-1:0]     w_sigs;
  gate_t                w_gate;
  logic                 w_a;
  logic                 w_b;
  logic                 w_c;
  logic                 w_maj;
  logic                 w_store_bit;
  logic [CNT_W-1:0]     w_g_in;
  logic                 w_last_gate;
  logic                 w_last_m;
  logic                 w_prog_ok;

  // Gate outputs at or beyond the limit are not yet valid and read as 0.
  function automatic logic rd_sig(input logic [SIG_N-1:0] sigs, input logic [SEL_W-1:0] sel,
                                  input logic [CNT_W-1:0] lim);
    logic [SEL_W:0] bound;
    bound = (SEL_W+1)'(8) + (SEL_W+1)'(lim);
    return sigs[sel] & ({1'b0, sel} < bound);
  endfunction

  always_comb begin
    w_sigs                    = '0;
    w_sigs[M_W:1]             = r_m;
    w_sigs[8 +: MAX_GATES]    = r_w;
  end

  assign w_gate      = r_prog[r_g[ADDR_W-1:0]];
  assign w_a         = rd_sig(w_sigs, w_gate.sel_a, r_g) ^ w_gate.inv_a;
  assign w_b         = rd_sig(w_sigs, w_gate.sel_b, r_g) ^ w_gate.inv_b;
  assign w_c         = rd_sig(w_sigs, w_gate.sel_c, r_g) ^ w_gate.inv_c;
  assign w_maj       = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
  assign w_store_bit = rd_sig(w_sigs, r_out_sel, r_gcnt);
  assign w_g_in      = (num_gates > CNT_W'(MAX_GATES)) ? CNT_W'(MAX_GATES) : num_gates;
  assign w_last_gate = (r_g == r_gcnt - CNT_W'(1));
  assign w_last_m    = (r_m == M_W'(TT_W - 1));
  assign w_prog_ok   = prog_we && ((r_state == S_IDLE) || (r_state == S_DONE)) &&
                       ({1'b0, prog_addr} < (ADDR_W+1)'(MAX_GATES));

  // State register plus registered status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_EVAL) || (w_state_nxt == S_STORE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (w_g_in == '0) ? S_STORE : S_EVAL;
      S_EVAL:  if (w_last_gate) w_state_nxt = S_STORE;
      S_STORE: begin
        if (w_last_m)             w_state_nxt = S_DONE;
        else if (r_gcnt == '0)    w_state_nxt = S_STORE;
        else                      w_state_nxt = S_EVAL;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_GATES; i++) r_prog[i] <= '0;
    end else if (w_prog_ok) begin
      r_prog[prog_addr] <= gate_t'(prog_data);
    end
  end

  // Evaluation datapath: minterm/gate counters, gate outputs, truth table.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gcnt    <= '0;
      r_g       <= '0;
      r_out_sel <= '0;
      r_m       <= '0;
      r_w       <= '0;
      r_tt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_gcnt    <= w_g_in;
          r_out_sel <= out_sel;
          r_m       <= '0;
          r_g       <= '0;
          r_w       <= '0;
          r_tt      <= '0;
        end
        S_EVAL: begin
          r_w[r_g[ADDR_W-1:0]] <= w_maj;
          r_g                  <= r_g + CNT_W'(1);
        end
        S_STORE: begin
          r_tt[r_m] <= w_store_bit;
          r_g       <= '0;
          r_w       <= '0;
          if (!w_last_m) r_m <= r_m + M_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef MAJ_NET_COMPARE_EN
  logic [TT_W-1:0] r_tt_exp;
  logic            r_mismatch;
  logic [M_W-1:0]  r_first;

  // Live comparison against the reference table; first_mismatch latches only once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tt_exp   <= '0;
      r_mismatch <= 1'b0;
      r_first    <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_tt_exp   <= tt_expected;
      r_mismatch <= 1'b0;
      r_first    <= '0;
    end else if (r_state == S_STORE && (w_store_bit != r_tt_exp[r_m])) begin
      r_mismatch <= 1'b1;
      if (!r_mismatch) r_first <= r_m;
    end
  end

  assign mismatch       = r_mismatch;
  assign first_mismatch = r_first;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign tt   = r_tt;

endmodule
